// File: rtl/bcd_display_scanner.sv
// bcd_display_scanner: time-multiplexed 4-digit common-anode 7-seg driver.
// Digits are snapshotted once per frame so a frame never mixes two values;
// the current slot's digit is decoded, optionally leading-zero blanked, and
// all display outputs are registered.
module bcd_display_scanner #(
  parameter int PRESCALE = 4,  // clock cycles per digit slot (>= 2)
  parameter int BLANK    = 1   // dark cycles at the start of each slot (< PRESCALE)
) (
  input  logic       clk,
  input  logic       reset,      // asynchronous, active-low
  input  logic [3:0] q0,
  input  logic [3:0] q1,
  input  logic [3:0] q2,
  input  logic [3:0] q3,
  input  logic [3:0] dp_sel,
  input  logic       blank_lz,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic       frame_done
);

  localparam int CW = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] LAST    = CW'(PRESCALE - 1);
  localparam logic [CW-1:0] BLANK_C = CW'(BLANK);

  logic [CW-1:0]   cnt;
  logic [1:0]      idx;
  logic [3:0][3:0] snap;     // snap[k] = snapshot of digit k
  logic [3:0]      snap_dp;

  logic       slot_end, frame_end, dark;
  logic [3:0] lz_mask, digit, an_nx;
  logic [6:0] seg_nx;
  logic       dp_nx;

  // Slot/frame boundaries and leading-zero mask for the current snapshot
  always_comb begin
    slot_end   = (cnt == LAST);
    frame_end  = slot_end && (idx == 2'd3);
    lz_mask    = '0;
    lz_mask[3] = blank_lz && (snap[3] == 4'd0);
    lz_mask[2] = lz_mask[3] && (snap[2] == 4'd0);
    lz_mask[1] = lz_mask[2] && (snap[1] == 4'd0);
    dark       = (cnt < BLANK_C) || lz_mask[idx];
  end

  // BCD to active-low {g,f,e,d,c,b,a}; invalid codes show a dash
  always_comb begin
    digit = snap[idx];
    case (digit)
      4'd0:    seg_nx = 7'h40;
      4'd1:    seg_nx = 7'h79;
      4'd2:    seg_nx = 7'h24;
      4'd3:    seg_nx = 7'h30;
      4'd4:    seg_nx = 7'h19;
      4'd5:    seg_nx = 7'h12;
      4'd6:    seg_nx = 7'h02;
      4'd7:    seg_nx = 7'h78;
      4'd8:    seg_nx = 7'h00;
      4'd9:    seg_nx = 7'h10;
      default: seg_nx = 7'h3F;
    endcase
    an_nx = ~(4'b0001 << idx);
    dp_nx = ~snap_dp[idx];
    if (dark) begin
      an_nx  = 4'hF;
      seg_nx = 7'h7F;
      dp_nx  = 1'b1;
    end
  end

  // Slot counter, per-frame snapshot and registered display outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt        <= '0;
      idx        <= '0;
      snap       <= '0;
      snap_dp    <= '0;
      frame_done <= 1'b0;
      an         <= 4'hF;
      seg        <= 7'h7F;
      dp         <= 1'b1;
    end else begin
      cnt        <= slot_end ? '0 : cnt + 1'b1;
      if (slot_end) idx <= idx + 2'd1;
      if (frame_end) begin
        snap    <= {q3, q2, q1, q0};
        snap_dp <= dp_sel;
      end
      frame_done <= frame_end;
      an         <= an_nx;
      seg        <= seg_nx;
      dp         <= dp_nx;
    end
  end

endmodule

// File: tb/tb_bcd_display_scanner.sv
// Directed bench for bcd_display_scanner with PRESCALE=4, BLANK=1.
// Each frame check covers the 16 cycles between two frame_done pulses:
// per slot one dark cycle followed by three lit cycles.
module tb_bcd_display_scanner;

  logic       clk, reset;
  logic [3:0] q0, q1, q2, q3, dp_sel;
  logic       blank_lz;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp, frame_done;

  int total = 0;
  int bad   = 0;

  bcd_display_scanner #(.PRESCALE(4), .BLANK(1)) dut (
    .clk(clk), .reset(reset),
    .q0(q0), .q1(q1), .q2(q2), .q3(q3),
    .dp_sel(dp_sel), .blank_lz(blank_lz),
    .an(an), .seg(seg), .dp(dp), .frame_done(frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_q(input logic [3:0] a3, input logic [3:0] a2,
                       input logic [3:0] a1, input logic [3:0] a0);
    q3 = a3; q2 = a2; q1 = a1; q0 = a0;
  endtask

  // Checks one frame starting right after a frame_done/release negedge.
  // s0..s3: expected segments per digit, dpm: expected lit dp per digit,
  // blk: digits expected dark. Optionally changes q0 after cycle chg_at.
  task automatic check_frame(input string tag,
                             input logic [6:0] s0, input logic [6:0] s1,
                             input logic [6:0] s2, input logic [6:0] s3,
                             input logic [3:0] dpm, input logic [3:0] blk,
                             input int chg_at, input logic [3:0] chg_q0);
    logic [6:0]  s [4];
    logic [11:0] exp;
    int          slot;
    s[0] = s0; s[1] = s1; s[2] = s2; s[3] = s3;
    for (int i = 0; i < 16; i++) begin
      @(posedge clk);
      @(negedge clk);
      slot = i / 4;
      if ((i % 4) == 0 || blk[slot])
        exp = {4'hF, 7'h7F, 1'b1};
      else
        exp = {~(4'b0001 << slot), s[slot], ~dpm[slot]};
      chk($sformatf("%s.disp[%0d]", tag, i), {4'h0, an, seg, dp}, {4'h0, exp});
      chk($sformatf("%s.fd[%0d]", tag, i), {15'h0, frame_done}, {15'h0, (i == 15)});
      if (i == chg_at) q0 = chg_q0;
    end
  endtask

  initial begin
    reset = 1'b1; blank_lz = 1'b0; dp_sel = 4'h0;
    set_q(4'd0, 4'd0, 4'd0, 4'd0);
    #2 reset = 1'b0;
    #1 chk("rst0", {4'h0, an, seg, dp, frame_done}, {4'h0, 4'hF, 7'h7F, 1'b1, 1'b0});

    // Decode and scan: q3..q0 = 1,2,3,4, dp on digit 2
    set_q(4'd1, 4'd2, 4'd3, 4'd4);
    dp_sel = 4'b0100;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    check_frame("f1", 7'h40, 7'h40, 7'h40, 7'h40, 4'b0000, 4'b0000, -1, 4'd0);
    check_frame("f2", 7'h19, 7'h30, 7'h24, 7'h79, 4'b0100, 4'b0000, -1, 4'd0);

    // Reset mid-frame while digit 0 is lit: outputs go dark immediately
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("pre_rst_lit", {12'h0, an}, {12'h0, 4'b1110});
    #2 reset = 1'b0;
    #1 chk("rst_mid", {4'h0, an, seg, dp, frame_done}, {4'h0, 4'hF, 7'h7F, 1'b1, 1'b0});
    blank_lz = 1'b1;
    dp_sel   = 4'h0;
    set_q(4'd0, 4'd0, 4'd0, 4'd7);
    repeat (3) begin
      @(negedge clk);
      chk("rst_hold", {4'h0, an, seg, dp, frame_done}, {4'h0, 4'hF, 7'h7F, 1'b1, 1'b0});
    end
    reset = 1'b1;

    // Leading-zero blanking
    check_frame("lz0",  7'h40, 7'h00, 7'h00, 7'h00, 4'b0000, 4'b1110, -1, 4'd0);
    check_frame("lz7",  7'h78, 7'h00, 7'h00, 7'h00, 4'b0000, 4'b1110, -1, 4'd0);
    set_q(4'd0, 4'd1, 4'd0, 4'd0);
    check_frame("lz7b", 7'h78, 7'h00, 7'h00, 7'h00, 4'b0000, 4'b1110, -1, 4'd0);
    check_frame("lzmid", 7'h40, 7'h40, 7'h79, 7'h00, 4'b0000, 4'b1000, -1, 4'd0);

    // Snapshot stability: q0 changes 3 -> 8 after digit 0's first lit cycle
    blank_lz = 1'b0;
    set_q(4'd0, 4'd0, 4'd0, 4'd3);
    check_frame("stab0", 7'h40, 7'h40, 7'h79, 7'h40, 4'b0000, 4'b0000, -1, 4'd0);
    check_frame("stab1", 7'h30, 7'h40, 7'h40, 7'h40, 4'b0000, 4'b0000, 1, 4'd8);
    check_frame("stab2", 7'h00, 7'h40, 7'h40, 7'h40, 4'b0000, 4'b0000, -1, 4'd0);

    // Invalid BCD on digit 1 is shown as a dash and never blanked;
    // dp requests on blanked digits stay off
    blank_lz = 1'b1;
    dp_sel   = 4'b1111;
    set_q(4'd0, 4'd0, 4'hC, 4'd8);
    check_frame("inv0", 7'h00, 7'h00, 7'h00, 7'h00, 4'b0000, 4'b1110, -1, 4'd0);
    check_frame("inv1", 7'h00, 7'h3F, 7'h00, 7'h00, 4'b0011, 4'b1100, -1, 4'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bcd_display_scanner.md
# bcd_display_scanner

- Consumes the four BCD digits produced by the stopwatch counter (q0 least significant, q3 most significant).
- Drives a time-multiplexed 4-digit common-anode seven-segment display.
- Snapshots the digits once per frame so a frame never shows mixed values, decodes BCD to segments, and blanks leading zeros on request.
- Sits between the stopwatch counter and the board display pins.

## Interface
- PRESCALE, default 4: clock cycles per digit slot; legal range ≥ 2 (board builds override, e.g. 50000).
- BLANK, default 1: cycles at the start of each slot with all anodes off (anti-ghosting); legal range 0 ≤ BLANK < PRESCALE.
- clk  input  1  single system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- q0, q1, q2, q3  input  4 each  BCD digits; q0 is least significant.
- dp_sel  input  4  decimal-point enable per digit; bit k belongs to digit k.
- blank_lz  input  1  1 = blank leading zeros.
- an  output  4  anode selects, active-low; bit k drives digit k.
- seg  output  7  segments, active-low, ordered {g,f,e,d,c,b,a}.
- dp  output  1  decimal point, active-low.
- frame_done  output  1  one-cycle pulse when a new snapshot is taken.

## Operation
- **Slot counter:**
  - cnt runs 0..PRESCALE-1 and wraps to 0.
  - idx runs 0..3 and advances (mod 4) on each edge where cnt == PRESCALE-1.
  - Frame length is 4·PRESCALE cycles.
- **Snapshot:**
  - On the edge where cnt == PRESCALE-1 and idx == 3, snap_q0..3 ← q0..q3 and snap_dp ← dp_sel.
  - Inputs are sampled at no other time.
  - Inputs are not assumed synchronous to the frame.
- **frame_done:** registered; high for exactly the one cycle following a snapshot edge.
- **Decode** of digit d = snap_q[idx], active-low:
  - 0→40h, 1→79h, 2→24h, 3→30h, 4→19h, 5→12h, 6→02h, 7→78h, 8→00h, 9→10h.
  - 10–15 (invalid BCD) → 3Fh (dash, g only).
- **Leading-zero blanking** (applies only when blank_lz = 1; blank_lz is sampled live, not snapshotted):
  - digit 3 is blanked if snap_q3 == 0;
  - digit 2 is blanked if snap_q3 == snap_q2 == 0;
  - digit 1 is blanked if snap_q3..snap_q1 are all 0;
  - digit 0 is never blanked.
  - A blanked digit keeps its anode high (off), with seg = 7Fh and dp = 1.
- **Anode drive:**
  - During cnt < BLANK, an = 1111, seg = 7Fh, dp = 1.
  - Otherwise an has bit idx low and the others high.
  - dp = ~snap_dp[idx] unless the digit is blanked.
- All outputs are registered from the current (cnt, idx, snapshot, blank_lz) values.

## Timing
- **Reset (reset low, asynchronous):**
  - cnt = 0, idx = 0, snapshots = 0.
  - an = 1111, seg = 7Fh, dp = 1, frame_done = 0.
- The first frame after reset displays the reset snapshot (0000). The first real snapshot is taken at the end of that frame, 4·PRESCALE edges after release.
- **Output latency:** an/seg/dp reflect the internal state one cycle earlier. With PRESCALE = 4 and BLANK = 1, the cycle pattern for slot k is: off, digit k, digit k, digit k.
- **Input-to-display latency:** an input change becomes visible between 1 and 4·PRESCALE+1 cycles later, depending on where in the frame it arrives. Visible means the snapshot has been taken and the output register has updated.
- **Reset mid-frame:** all state clears immediately and outputs go dark in the same cycle. The partial frame is discarded and no frame_done pulse is generated.
- **Simultaneous events:** input change on the snapshot edge → the value present at that edge is captured.
- **Degenerate blanking:** BLANK = 0 means no dark cycles; each anode is on for the full PRESCALE cycles.

## Test plan
1. **Reset:** reset low for 3 cycles, mid-operation → an = 1111, seg = 7Fh, dp = 1, frame_done = 0 within the same cycle. After release, the first frame shows 40h on digit 0 only. The other digits show 40h too if blank_lz = 0.
2. **Decode and scan:** q3..q0 = 1,2,3,4, dp_sel = 0100, blank_lz = 0, PRESCALE = 4, BLANK = 1.
   - The second frame shows digit 0 = 19h, digit 1 = 30h, digit 2 = 24h with dp = 0, digit 3 = 79h.
   - Each digit has 1 dark cycle followed by 3 lit cycles.
   - frame_done pulses every 16 cycles.
3. **Leading-zero blanking:** q = 0,0,0,7 and blank_lz = 1 → only digit 0 is lit (78h). q = 0,1,0,0 → digits 3 and above stay dark; digits 2, 1 and 0 show 79h, 40h, 40h respectively, i.e. the middle zeros are shown.
4. **Snapshot stability:** change q0 from 3 to 8 in the middle of a frame → the rest of that frame still shows 30h on digit 0. The next frame shows 00h.
5. **Invalid BCD:** q1 = 4'hC → digit 1 shows 3Fh. Digits are never blanked because of an invalid value.
6. **Stopwatch integration:** connect to a counter running up from 0000, then counting down after a reset → the displayed frames match counter values sampled at the frame_done instants, and no frame shows mixed digits.
